note_scroll_scheduler: RTL and testbench

- Manages a fixed pool of on-screen note slots for the falling-note display.
- Accepts note codes from the song player over a valid/ready handshake and allocates each to a free slot at the top of the note column.
- Advances every active slot down the screen once per video frame and retires slots that leave the visible region.
- Drives the x1/y1/note/valid inputs of SLOTS parallel note_display instances, so each instance renders one 32x8 note label.

---
 rtl/note_scroll_scheduler.sv | 155 +++++++++++++++
 tb/tb_note_scroll_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/note_scroll_scheduler.sv
// Falling-note slot scheduler: admits note codes into a fixed slot pool and scrolls them once per frame.
// Optional NOTE_SCHED_EVICT_EN: when every slot is busy, overwrite the lowest-on-screen slot instead of stalling.
module note_scroll_scheduler #(
  parameter int          SLOTS   = 4,
  parameter logic [10:0] X_COL   = 11'd64,
  parameter logic [9:0]  Y_START = 10'd16,
  parameter logic [9:0]  Y_STEP  = 10'd8,
  parameter logic [9:0]  Y_LIMIT = 10'd464,
  parameter logic [9:0]  MIN_GAP = 10'd8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  clear,
  input  logic                  new_note_valid,
  input  logic [5:0]            new_note,
  output logic                  new_note_ready,
  output logic [SLOTS*11-1:0]   slot_x1,
  output logic [SLOTS*10-1:0]   slot_y1,
  output logic [SLOTS*6-1:0]    slot_note,
  output logic [SLOTS-1:0]      slot_valid,
  output logic                  busy
);

  localparam int          IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [10:0] GAP_Y = {1'b0, Y_START} + {1'b0, MIN_GAP};

  typedef enum logic {IDLE = 1'b0, SCROLL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pending_q, pending_d;
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [9:0]      y1_q   [SLOTS];
  logic [9:0]      y1_d   [SLOTS];
  logic [5:0]      note_q [SLOTS];
  logic [5:0]      note_d [SLOTS];

  logic            gap_ok, free_found, slot_ok, accept;
  logic [IW-1:0]   alloc_idx;
  logic [10:0]     ny;

  // Slot selection: lowest free slot, or (evict build, pool full) the slot furthest down the screen.
  always_comb begin
    gap_ok     = 1'b1;
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && ({1'b0, y1_q[i]} < GAP_Y)) gap_ok = 1'b0;
      if (!valid_q[i]) begin
        free_found = 1'b1;
        alloc_idx  = IW'(i);
      end
    end
`ifdef NOTE_SCHED_EVICT_EN
    if (!free_found) begin
      alloc_idx = '0;
      for (int i = 1; i < SLOTS; i++) begin
        if (y1_q[i] > y1_q[alloc_idx]) alloc_idx = IW'(i);
      end
    end
    slot_ok = 1'b1;
`else
    slot_ok = free_found;
`endif
  end

  // Handshake: the note transfers on a clock edge where new_note_valid && new_note_ready.
  assign new_note_ready = (state_q == IDLE) && !frame_tick && !clear && !reset &&
                          ((new_note == 6'd0) || (slot_ok && gap_ok));
  assign accept = new_note_valid && new_note_ready;
  assign ny     = {1'b0, y1_q[idx_q]} + {1'b0, Y_STEP};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    y1_d      = y1_q;
    note_d    = note_q;
    if (clear) begin
      state_d   = IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
      valid_d   = '0;
      for (int i = 0; i < SLOTS; i++) begin
        y1_d[i]   = '0;
        note_d[i] = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick || pending_q) begin
            state_d   = SCROLL;
            idx_d     = '0;
            pending_d = 1'b0;
          end
          // A pending rerun can coincide with an accepted note; the new slot joins that sweep.
          if (accept && (new_note != 6'd0)) begin
            valid_d[alloc_idx] = 1'b1;
            y1_d[alloc_idx]    = Y_START;
            note_d[alloc_idx]  = new_note;
          end
        end
        SCROLL: begin
          if (valid_q[idx_q]) begin
            if (ny >= {1'b0, Y_LIMIT}) begin
              valid_d[idx_q] = 1'b0;
              y1_d[idx_q]    = '0;
              note_d[idx_q]  = '0;
            end else begin
              y1_d[idx_q] = ny[9:0];
            end
          end
          if (frame_tick) pending_d = 1'b1;
          if (idx_q == IW'(SLOTS - 1)) state_d = IDLE;
          else                         idx_d   = idx_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        y1_q[i]   <= '0;
        note_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      y1_q      <= y1_d;
      note_q    <= note_d;
    end
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      slot_x1[11*i +: 11]  = X_COL;
      slot_y1[10*i +: 10]  = y1_q[i];
      slot_note[6*i +: 6]  = note_q[i];
    end
  end

  assign slot_valid = valid_q;
  assign busy       = (state_q == SCROLL);

endmodule

// File: tb/tb_note_scroll_scheduler.sv
// Directed bench for note_scroll_scheduler: vector table for admission/scroll, then hand sequences.
// Build with +define+NOTE_SCHED_EVICT_EN to check the evicting variant.
module tb_note_scroll_scheduler;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        clear;
  logic        new_note_valid;
  logic [5:0]  new_note;
  logic        new_note_ready;
  logic [43:0] slot_x1;
  logic [39:0] slot_y1;
  logic [23:0] slot_note;
  logic [3:0]  slot_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  note_scroll_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .clear          (clear),
    .new_note_valid (new_note_valid),
    .new_note       (new_note),
    .new_note_ready (new_note_ready),
    .slot_x1        (slot_x1),
    .slot_y1        (slot_y1),
    .slot_note      (slot_note),
    .slot_valid     (slot_valid),
    .busy           (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ft;
    logic        clr;
    logic        nv;
    logic [5:0]  nn;
    logic        rdy;
    logic        bsy;
    logic [3:0]  valid;
    logic [39:0] y1;
    logic [23:0] note;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic cyc(input logic ft, input logic clr, input logic nv, input logic [5:0] nn);
    @(negedge clk);
    frame_tick     = ft;
    clear          = clr;
    new_note_valid = nv;
    new_note       = nn;
    #1;
  endtask

  task automatic offer(input logic [5:0] nn, input logic exp_rdy, input string name);
    cyc(1'b0, 1'b0, 1'b1, nn);
    chk(name, 64'(new_note_ready), 64'(exp_rdy));
  endtask

  // One tick followed by the four sweep cycles; returns with the machine about to go idle.
  task automatic frame();
    cyc(1'b1, 1'b0, 1'b0, 6'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic chk_slots(input string name, input logic [3:0] v, input logic [39:0] y,
                           input logic [23:0] n);
    chk({name, "_valid"}, 64'(slot_valid), 64'(v));
    chk({name, "_y1"},    64'(slot_y1),    64'(y));
    chk({name, "_note"},  64'(slot_note),  64'(n));
  endtask

  logic [11:0] ft_pat;
  logic [11:0] busy_pat;

  initial begin
    frame_tick     = 1'b0;
    clear          = 1'b0;
    new_note_valid = 1'b1;
    new_note       = 6'd5;
    reset          = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("ready_in_reset", 64'(new_note_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    new_note_valid = 1'b0;
    #1;
    chk_slots("reset", 4'b0000, 40'd0, 24'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_x1", 64'(slot_x1), 64'({4{11'd64}}));

    // Table: slot state shown is the registered state before the row's clock edge.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 4'b0000, 40'd0, 24'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 4'b0001, {30'd0, 10'd16}, {18'd0, 6'd5}};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 4'b0001, {30'd0, 10'd16}, {18'd0, 6'd5}};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b1, 4'b0001, {30'd0, 10'd16}, {18'd0, 6'd5}};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b1, 4'b0001, {30'd0, 10'd24}, {18'd0, 6'd5}};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b1, 4'b0001, {30'd0, 10'd24}, {18'd0, 6'd5}};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b1, 4'b0001, {30'd0, 10'd24}, {18'd0, 6'd5}};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 1'b0, 4'b0001, {30'd0, 10'd24}, {18'd0, 6'd5}};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 4'b0011,
                {20'd0, 10'd16, 10'd24}, {12'd0, 6'd7, 6'd5}};

    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].ft, vecs[i].clr, vecs[i].nv, vecs[i].nn);
      chk($sformatf("vec%0d_ready", i), 64'(new_note_ready), 64'(vecs[i].rdy));
      chk($sformatf("vec%0d_busy", i),  64'(busy),           64'(vecs[i].bsy));
      chk_slots($sformatf("vec%0d", i), vecs[i].valid, vecs[i].y1, vecs[i].note);
    end

    // Fill the pool: one frame between admissions satisfies the gap rule.
    frame();
    offer(6'd9, 1'b1, "accept_n9");
    frame();
    offer(6'd11, 1'b1, "accept_n11");
    frame();
    offer(6'd0, 1'b1, "rest_full_ready");
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk_slots("after_rest", 4'b1111, {10'd24, 10'd32, 10'd40, 10'd48},
              {6'd11, 6'd9, 6'd7, 6'd5});
`ifdef NOTE_SCHED_EVICT_EN
    offer(6'd13, 1'b1, "full_evict_ready");
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk_slots("evict", 4'b1111, {10'd24, 10'd32, 10'd40, 10'd16},
              {6'd11, 6'd9, 6'd7, 6'd13});
`else
    offer(6'd13, 1'b0, "full_backpressure");
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk_slots("full_hold", 4'b1111, {10'd24, 10'd32, 10'd40, 10'd48},
              {6'd11, 6'd9, 6'd7, 6'd5});
`endif
    cyc(1'b0, 1'b1, 1'b1, 6'd3);
    chk("clear_ready", 64'(new_note_ready), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk_slots("after_clear", 4'b0000, 40'd0, 24'd0);

    // Tick during a sweep sets pending (one IDLE gap, then a rerun); a further tick is dropped.
    offer(6'd5, 1'b1, "accept_for_pending");
    ft_pat   = 12'b0000_0000_1101;
    busy_pat = 12'b0011_1101_1110;
    for (int c = 0; c < 12; c++) begin
      cyc(ft_pat[c], 1'b0, 1'b0, 6'd0);
      chk($sformatf("pend_busy_c%0d", c), 64'(busy), 64'(busy_pat[c]));
    end
    chk_slots("pend_total", 4'b0001, {30'd0, 10'd32}, {18'd0, 6'd5});

    // Clear mid-sweep with a simultaneous tick: no rerun afterwards.
    cyc(1'b1, 1'b0, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk("pre_clear_busy", 64'(busy), 64'd1);
    cyc(1'b1, 1'b1, 1'b0, 6'd0);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 6'd0);
      chk($sformatf("mid_clear_busy%0d", c), 64'(busy), 64'd0);
    end
    chk_slots("mid_clear", 4'b0000, 40'd0, 24'd0);

    // Retire boundary: 456+8 = 464 retires, 448+8 = 456 stays.
    offer(6'd5, 1'b1, "limit_a");
    frame();
    offer(6'd6, 1'b1, "limit_b");
    repeat (54) frame();
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk_slots("limit_pre", 4'b0011, {20'd0, 10'd448, 10'd456}, {12'd0, 6'd6, 6'd5});
    frame();
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk_slots("limit_retire", 4'b0010, {20'd0, 10'd456, 10'd0}, {12'd0, 6'd6, 6'd0});
    frame();
    cyc(1'b0, 1'b0, 1'b0, 6'd0);
    chk_slots("limit_all_gone", 4'b0000, 40'd0, 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
